sample_tick_gen: RTL
====================

# sample_tick_gen

Multi-channel, parametrised sample-rate tick generator; it replaces the fixed 256-cycle sample strobe. Each channel has a runtime-programmable period, an enable, and glitch-free period updates staged until the channel's next wrap. Sits between the system clock domain and the wave-shaper / oscillator blocks, each of which consumes one channel's single-cycle `tick`.

## Interface
- `CNT_WIDTH`, 8: width of each channel's counter and period register.
- `NUM_CH`, 4: number of independent channels (≥1).
- `clk` input 1: system clock, all logic on rising edge.
- `n_rst` input 1: reset, synchronous and active-low. One clock; reset is synchronous and active-low.
- `ch_en` input NUM_CH: per-channel run enable.
- `cfg_wr` input 1: single-cycle period write strobe.
- `cfg_ch` input $clog2(NUM_CH) (min 1): target channel of the write; out-of-range values ignore the write.
- `cfg_period` input CNT_WIDTH: new period value P (tick every P+1 enabled cycles).
- `tick` output NUM_CH: per-channel one-cycle sample strobe.
- `pending` output NUM_CH: channel has a staged period not yet applied.
- `align` input 1: present only with `SAMPLE_TICK_ALIGN_EN`.

## Operation
- Per channel: active period `per`, staged period `stg`, flag `pend`, counter `cnt`.
- `tick[i] = ch_en[i] && cnt == per`, decoded from registers, no extra flop.
- Enabled: if `cnt == per`, `cnt` goes to 0 (wrap); otherwise `cnt` increments by 1. Unsigned, CNT_WIDTH bits, never exceeds `per`.
- Disabled: `cnt` is forced to 0; tick low.
- Write (`cfg_wr`, valid `cfg_ch`): `stg` gets `cfg_period`; `pend` is set. A later write before apply overwrites `stg` (last write wins).
- Apply: on a wrap, or any cycle the channel is disabled, if `pend`, then `per` gets `stg` and `pend` clears.
- Write in the same cycle as a wrap or disabled cycle on that channel: the written value is applied directly to `per` at that edge; `pend` stays/ends 0.
- `per == 0`: tick every enabled cycle.
- Period shrink below current `cnt` is impossible, because updates only land at `cnt == 0`.
- Channels are fully independent; writes to one never disturb another's `cnt`.

## Timing
- Reset (`n_rst` low at an edge): all `cnt` = 0, `per` = all-ones (255 at default width), `stg` = 0, `pend` = 0, so `tick` = 0 and `pending` = 0. Reset overrides every other input.
- Reset values give legacy behaviour: with `ch_en` tied high from reset release, the first tick is during the cycle after the 255th enabled edge, then one every 256 cycles.
- Enable rising: `cnt` = 0 in that cycle. The tick is seen in the cycle where `cnt == per`, i.e. P cycles later. Period is P+1 cycles.
- `pending` is a direct register output. It rises the cycle after `cfg_wr` and falls the cycle after the applying wrap.
- New period is first observable as the interval following the wrap tick that applied it.
- Reset mid-period discards `cnt` and any staged value.

## Configuration
- `SAMPLE_TICK_ALIGN_EN` defined:
  - Adds the `align` input.
  - While `align` is high, every channel's `cnt` is forced to 0 and all ticks are suppressed that cycle.
  - Pending periods are applied as on a wrap.
  - `align` has priority over wrap/increment and below reset.
  - Used to phase-lock voices on note-on.
- Undefined: no `align` port; channels free-run independently.

## Structure
- Package `sample_tick_pkg`:
  - `CNT_WIDTH` default.
  - Reset-period constant (all-ones).
  - Channel-index width function/constant.
- Sub-module `sample_tick_chan`:
  - One channel holding `cnt`, `per`, `stg`, `pend`.
  - Inputs: `en`, `wr`, `wr_data`, `align` (tied 0 when the macro is off).
  - Outputs: `tick`, `pending`.
- Top: instantiates NUM_CH channels via generate and decodes `cfg_ch` into per-channel `wr`.

## Test plan
- Reset, all `ch_en`=1, no writes: each `tick` first high 255 edges after release, then every 256 cycles; `pending` stays 0.
- Write `cfg_period`=3 to ch1 mid-count at `cnt`=100: `pending[1]` = 1 until ch1's next wrap; ticks then every 4 cycles; other channels unaffected.
- Write P=9 then P=4 to ch0 before wrap: only 4 is applied. A write landing on the exact wrap cycle is applied immediately, with `pending[0]` never rising.
- ch2 disabled, write P=0, enable: `pending[2]` clears the cycle after the write; once enabled, `tick[2]` is high every cycle.
- Assert `n_rst` low for one cycle mid-period with a staged value: all ticks and `pending` go 0; period returns to 255.
- With `SAMPLE_TICK_ALIGN_EN` and channels at different phases: pulse `align` and check that no ticks occur that cycle, then all channels with equal P tick in the same cycle.

Source files
------------

// File: rtl/sample_tick_gen_pkg.sv
// Shared constants and helpers for the multi-channel sample tick generator.
// Optional phase-align feature: SAMPLE_TICK_ALIGN_EN.
package sample_tick_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 8;
  localparam int unsigned NUM_CH_DEF    = 4;

  // Period register reset value is all-ones, giving the legacy 256-cycle strobe.
  localparam logic RST_PERIOD_FILL = 1'b1;

  function automatic int unsigned ch_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_tick_gen_if.sv
// Configuration/strobe bundle between the tick generator and its consumers.
// The align input exists only when SAMPLE_TICK_ALIGN_EN is defined.
interface sample_tick_gen_if
  import sample_tick_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int unsigned NUM_CH    = NUM_CH_DEF
);
  localparam int unsigned CH_W = ch_idx_width(NUM_CH);

  logic [NUM_CH-1:0]    ch_en;
  logic                 cfg_wr;
  logic [CH_W-1:0]      cfg_ch;
  logic [CNT_WIDTH-1:0] cfg_period;
  logic [NUM_CH-1:0]    tick;
  logic [NUM_CH-1:0]    pending;

`ifdef SAMPLE_TICK_ALIGN_EN
  logic                 align;

  modport master (output ch_en, cfg_wr, cfg_ch, cfg_period, align,
                  input  tick, pending);
  modport slave  (input  ch_en, cfg_wr, cfg_ch, cfg_period, align,
                  output tick, pending);
`else
  modport master (output ch_en, cfg_wr, cfg_ch, cfg_period,
                  input  tick, pending);
  modport slave  (input  ch_en, cfg_wr, cfg_ch, cfg_period,
                  output tick, pending);
`endif

endinterface

// File: rtl/sample_tick_gen_chan.sv
// One tick channel: free-running counter with active and staged period registers.
// Staged periods land only when the counter restarts at 0.
module sample_tick_chan
  import sample_tick_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 en,
  input  logic                 wr,
  input  logic [CNT_WIDTH-1:0] wr_data,
  input  logic                 align,
  output logic                 tick,
  output logic                 pending
);

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] per;
  logic [CNT_WIDTH-1:0] stg;
  logic                 pend;
  logic                 at_top;
  logic                 restart;

  always_comb begin
    at_top  = (cnt == per);
    restart = align || !en || at_top;
  end

  assign tick    = en && at_top && !align;
  assign pending = pend;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt  <= '0;
      per  <= {CNT_WIDTH{RST_PERIOD_FILL}};
      stg  <= '0;
      pend <= 1'b0;
    end else if (restart) begin
      cnt <= '0;
      // A write coinciding with a restart bypasses staging entirely.
      if (wr) begin
        per  <= wr_data;
        stg  <= wr_data;
        pend <= 1'b0;
      end else if (pend) begin
        per  <= stg;
        pend <= 1'b0;
      end
    end else begin
      cnt <= cnt + 1'b1;
      if (wr) begin
        stg  <= wr_data;
        pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sample_tick_gen.sv
// Multi-channel sample-rate tick generator; decodes period writes per channel.
// Define SAMPLE_TICK_ALIGN_EN to add the global phase-align input.
module sample_tick_gen
  import sample_tick_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int unsigned NUM_CH    = NUM_CH_DEF
) (
  input logic               clk,
  input logic               n_rst,
  sample_tick_gen_if.slave  bus
);

  localparam int unsigned CH_W = ch_idx_width(NUM_CH);

  logic [NUM_CH-1:0] wr;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pending;
  logic              align;

`ifdef SAMPLE_TICK_ALIGN_EN
  assign align = bus.align;
`else
  assign align = 1'b0;
`endif

  assign bus.tick    = tick;
  assign bus.pending = pending;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Indices at or beyond NUM_CH match no channel, so such writes are dropped.
    assign wr[i] = bus.cfg_wr && (bus.cfg_ch == CH_W'(i));

    sample_tick_chan #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_chan (
      .clk     (clk),
      .n_rst   (n_rst),
      .en      (bus.ch_en[i]),
      .wr      (wr[i]),
      .wr_data (bus.cfg_period),
      .align   (align),
      .tick    (tick[i]),
      .pending (pending[i])
    );
  end

endmodule
